// File: rtl/mvm_weight_packetizer_pkg.sv
// Shared widths, flit field offsets and FSM encoding for the
// weight packetizer and the mvm_top decode logic.
package mvm_weight_packetizer_pkg;

  localparam int DATAW  = 32;
  localparam int ADDRW  = 9;
  localparam int NUM_RF = 64;
  localparam int CNTW   = 16;

  localparam int TDATAW = 128;
  localparam int IDW    = 32;
  localparam int DESTW  = 12;
  localparam int USERW  = 32;

  localparam int WDATA_LSB = 0;
  localparam int WADDR_LSB = WDATA_LSB + DATAW;
  localparam int RFSEL_LSB = WADDR_LSB + ADDRW;
  localparam int FLIT_USED = RFSEL_LSB + NUM_RF;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } wp_state_e;

endpackage

// File: rtl/mvm_weight_packetizer_if.sv
// AXI-stream flit bundle between the packetizer and the NoC port
// of mvm_top.
interface mvm_weight_packetizer_if;
  import mvm_weight_packetizer_pkg::*;

  logic              TVALID;
  logic              TREADY;
  logic [TDATAW-1:0] TDATA;
  logic              TLAST;
  logic [IDW-1:0]    TID;
  logic [USERW-1:0]  TUSER;
  logic [DESTW-1:0]  TDEST;

  modport master (
    output TVALID,
    input  TREADY,
    output TDATA,
    output TLAST,
    output TID,
    output TUSER,
    output TDEST
  );

  modport slave (
    input  TVALID,
    output TREADY,
    input  TDATA,
    input  TLAST,
    input  TID,
    input  TUSER,
    input  TDEST
  );

endinterface

// File: rtl/mvm_weight_packetizer.sv
// Packs a stream of weight words into single-flit NoC packets that
// load the MVM register files, round-robin across RFs.
module mvm_weight_packetizer
  import mvm_weight_packetizer_pkg::*;
(
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 CFG_VALID,
  output logic                 CFG_READY,
  input  logic [ADDRW-1:0]     CFG_BASE_ADDR,
  input  logic [CNTW-1:0]      CFG_NUM_WORDS,
  input  logic [DESTW-1:0]     CFG_DEST,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  input  logic [DATAW-1:0]     IN_DATA,
  mvm_weight_packetizer_if.master AXIS_M,
  output logic                 BUSY,
  output logic                 DONE
);

  localparam int RFW = $clog2(NUM_RF);

  wp_state_e         state_q;
  logic [CNTW-1:0]   count_q;
  logic [CNTW-1:0]   sent_q;
  logic [RFW-1:0]    rf_idx_q;
  logic [RFW-1:0]    rf_idx_d;
  logic [ADDRW-1:0]  addr_q;
  logic [ADDRW-1:0]  addr_d;
  logic [DESTW-1:0]  dest_q;
  logic              tvalid_q;
  logic [TDATAW-1:0] tdata_q;
  logic [TDATAW-1:0] flit_d;
  logic              zdone_q;

  logic              out_fire;
  logic              in_ready;
  logic              in_fire;
  logic              last_word;
  logic              rf_wrap;
  logic [NUM_RF-1:0] rf_sel;

  always_comb begin
    out_fire  = tvalid_q && AXIS_M.TREADY;
    in_ready  = (state_q == ST_RUN) &&
                (sent_q < count_q) &&
                (!tvalid_q || AXIS_M.TREADY);
    in_fire   = IN_VALID && in_ready;
    last_word = in_fire && (sent_q == count_q - CNTW'(1));
  end

  // Column-major walk: RF index first, address advances on wrap.
  always_comb begin
    rf_wrap  = (rf_idx_q == RFW'(NUM_RF - 1));
    rf_idx_d = rf_wrap ? '0 : rf_idx_q + RFW'(1);
    addr_d   = rf_wrap ? addr_q + ADDRW'(1) : addr_q;
  end

  always_comb begin
    rf_sel = NUM_RF'(1) << rf_idx_q;
    flit_d = '0;
    flit_d[WDATA_LSB +: DATAW]  = IN_DATA;
    flit_d[WADDR_LSB +: ADDRW]  = addr_q;
    flit_d[RFSEL_LSB +: NUM_RF] = rf_sel;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      sent_q   <= '0;
      rf_idx_q <= '0;
      addr_q   <= '0;
      dest_q   <= '0;
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      zdone_q  <= 1'b0;
    end else begin
      zdone_q <= 1'b0;

      // A load in the same cycle as a handshake replaces the flit.
      if (in_fire) begin
        tvalid_q <= 1'b1;
        tdata_q  <= flit_d;
      end else if (out_fire) begin
        tvalid_q <= 1'b0;
      end

      unique case (state_q)
        ST_IDLE: begin
          if (CFG_VALID) begin
            if (CFG_NUM_WORDS == '0) begin
              zdone_q <= 1'b1;
            end else begin
              state_q  <= ST_RUN;
              count_q  <= CFG_NUM_WORDS;
              sent_q   <= '0;
              rf_idx_q <= '0;
              addr_q   <= CFG_BASE_ADDR;
              dest_q   <= CFG_DEST;
            end
          end
        end
        ST_RUN: begin
          if (in_fire) begin
            sent_q   <= sent_q + CNTW'(1);
            rf_idx_q <= rf_idx_d;
            addr_q   <= addr_d;
            if (last_word) state_q <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (out_fire) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CFG_READY     = (state_q == ST_IDLE);
  assign BUSY          = (state_q != ST_IDLE);
  assign IN_READY      = in_ready;
  assign DONE          = zdone_q ||
                         ((state_q == ST_DRAIN) && out_fire);

  assign AXIS_M.TVALID = tvalid_q;
  assign AXIS_M.TDATA  = tdata_q;
  assign AXIS_M.TLAST  = tvalid_q;
  assign AXIS_M.TID    = '0;
  assign AXIS_M.TUSER  = '0;
  assign AXIS_M.TDEST  = dest_q;

endmodule

// File: tb/tb_mvm_weight_packetizer.sv
// Randomized bench for mvm_weight_packetizer with a queue-based
// reference model of the expected flit stream.
module tb_mvm_weight_packetizer;
  import mvm_weight_packetizer_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             cfg_valid;
  logic             cfg_ready;
  logic [ADDRW-1:0] cfg_base;
  logic [CNTW-1:0]  cfg_num;
  logic [DESTW-1:0] cfg_dest;
  logic             in_valid;
  logic             in_ready;
  logic [DATAW-1:0] in_data;
  logic             busy;
  logic             done;

  mvm_weight_packetizer_if axis();

  mvm_weight_packetizer dut (
    .CLK           (clk),
    .RST_N         (rst_n),
    .CFG_VALID     (cfg_valid),
    .CFG_READY     (cfg_ready),
    .CFG_BASE_ADDR (cfg_base),
    .CFG_NUM_WORDS (cfg_num),
    .CFG_DEST      (cfg_dest),
    .IN_VALID      (in_valid),
    .IN_READY      (in_ready),
    .IN_DATA       (in_data),
    .AXIS_M        (axis),
    .BUSY          (busy),
    .DONE          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TDATAW-1:0] data;
    bit                last;
  } exp_t;

  exp_t              exp_q[$];
  logic [TDATAW-1:0] cap[$];
  int                fcyc[$];
  logic [DESTW-1:0]  exp_dest;
  int                n_chk = 0;
  int                n_fail = 0;
  int                done_seen = 0;
  bit                zero_pending = 0;
  int                tr_mode = 0;
  int                cyc_n = 0;
  int                first_in_cyc = 0;
  bit                prev_stall = 0;
  logic [TDATAW-1:0] prev_data;

  task automatic chk(input string nm,
                     input logic [TDATAW-1:0] act,
                     input logic [TDATAW-1:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // Word k -> RF (k mod 64) at address base + k/64, mod 512.
  function automatic logic [TDATAW-1:0] model_flit(
      input logic [DATAW-1:0] w, input int k, input int base);
    logic [TDATAW-1:0] f;
    int a;
    int s;
    f = '0;
    a = (base + k / NUM_RF) % (1 << ADDRW);
    s = k % NUM_RF;
    f[31:0] = w;
    for (int b = 0; b < ADDRW; b++) f[32 + b] = a[b];
    f[41 + s] = 1'b1;
    return f;
  endfunction

  function automatic logic [TDATAW-1:0] capx(input int i);
    if (i < cap.size()) return cap[i];
    return 'x;
  endfunction

  always @(posedge clk) cyc_n <= cyc_n + 1;

  initial begin
    int ph;
    ph = 0;
    axis.TREADY = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (tr_mode)
        0: axis.TREADY = 1'b1;
        1: axis.TREADY = ($urandom_range(0, 3) != 0);
        default: begin
          axis.TREADY = (ph == 0) || (ph == 3);
          ph = (ph + 1) % 4;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    bit   hs;
    bit   exp_done;
    exp_t e;
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      hs = axis.TVALID && axis.TREADY;
      exp_done = zero_pending;
      zero_pending = 0;
      if (prev_stall) begin
        chk("hold_valid", axis.TVALID, 1);
        chk("hold_data", axis.TDATA, prev_data);
      end
      if (hs) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_flit", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("tdata", axis.TDATA, e.data);
          chk("tdest", axis.TDEST, exp_dest);
          chk("tlast", axis.TLAST, 1);
          chk("tid", axis.TID, 0);
          chk("tuser", axis.TUSER, 0);
          cap.push_back(axis.TDATA);
          fcyc.push_back(cyc_n);
          if (e.last) exp_done = 1;
        end
      end
      chk("done", done, exp_done);
      if (done) done_seen++;
      chk("cfg_ready", cfg_ready, !busy);
      if (axis.TVALID && !axis.TREADY)
        chk("in_ready_stall", in_ready, 0);
      if (!busy) begin
        chk("idle_tvalid", axis.TVALID, 0);
        chk("idle_in_ready", in_ready, 0);
      end
      prev_stall = axis.TVALID && !axis.TREADY;
      prev_data  = axis.TDATA;
    end
  end

  task automatic run_job(input int base, input int count,
                         input int dest, input bit fixed,
                         input int in_mode, input bit spam,
                         input int abort_at);
    logic [DATAW-1:0] words[$];
    logic [DATAW-1:0] w;
    exp_t e;
    int   k;
    int   cyc;
    bit   hs;
    @(posedge clk);
    #1;
    cap.delete();
    fcyc.delete();
    done_seen = 0;
    for (int i = 0; i < count; i++) begin
      w = fixed ? DATAW'(32'hA0 + i) : DATAW'($urandom);
      words.push_back(w);
      e.data = model_flit(w, i, base);
      e.last = (i == count - 1);
      exp_q.push_back(e);
    end
    exp_dest  = DESTW'(dest);
    cfg_valid = 1'b1;
    cfg_base  = ADDRW'(base);
    cfg_num   = CNTW'(count);
    cfg_dest  = DESTW'(dest);
    cyc = 0;
    forever begin
      @(negedge clk);
      if (cfg_ready) break;
      if (++cyc > 100) begin
        chk("cfg_timeout", 1, 0);
        cfg_valid = 1'b0;
        return;
      end
    end
    @(posedge clk);
    #1;
    cfg_valid = spam && (count > 0);
    cfg_dest  = ~DESTW'(dest);
    cfg_num   = CNTW'($urandom_range(1, 9));
    if (count == 0) zero_pending = 1;
    k = 0;
    cyc = 0;
    while (k < count) begin
      in_valid = (in_mode == 0) || ($urandom_range(0, 2) != 0);
      in_data  = words[k];
      @(negedge clk);
      hs = in_valid && in_ready;
      if (hs && k == 0) first_in_cyc = cyc_n;
      @(posedge clk);
      #1;
      if (hs) k++;
      if (abort_at >= 0 && k == abort_at) begin
        in_valid  = 1'b0;
        cfg_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_tvalid", axis.TVALID, 0);
        chk("rst_tdata", axis.TDATA, 0);
        chk("rst_tdest", axis.TDEST, 0);
        chk("rst_tlast", axis.TLAST, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_cfg_ready", cfg_ready, 1);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        chk("abort_no_done", done_seen, 0);
        return;
      end
      if (++cyc > 5000) begin
        chk("in_timeout", 1, 0);
        break;
      end
    end
    in_valid  = 1'b0;
    cfg_valid = 1'b0;
    cyc = 0;
    while (done_seen == 0 && cyc < 2000) begin
      @(posedge clk);
      cyc++;
    end
    if (done_seen == 0) chk("done_timeout", 1, 0);
    repeat (3) @(posedge clk);
    chk("done_count", done_seen, 1);
    chk("exp_empty", exp_q.size(), 0);
    chk("flit_count", cap.size(), count);
  endtask

  initial begin
    logic [TDATAW-1:0] f;
    cfg_valid = 1'b0;
    cfg_base  = '0;
    cfg_num   = '0;
    cfg_dest  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    #12;
    chk("reset_tvalid", axis.TVALID, 0);
    chk("reset_cfg_ready", cfg_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_tlast", axis.TLAST, 0);
    @(negedge clk);
    rst_n = 1'b1;

    tr_mode = 0;
    run_job(0, 3, 'h002, 1, 0, 0, -1);
    chk("t1_flit0", capx(0), 128'h0000_0000_0000_0000_0000_0200_0000_00A0);
    chk("t1_flit1", capx(1), 128'h0000_0000_0000_0000_0000_0400_0000_00A1);
    chk("t1_flit2", capx(2), 128'h0000_0000_0000_0000_0000_0800_0000_00A2);
    if (fcyc.size() == 3) begin
      chk("t1_latency", fcyc[0] - first_in_cyc, 1);
      chk("t1_rate", fcyc[2] - fcyc[0], 2);
    end else begin
      chk("t1_fcyc", fcyc.size(), 3);
    end

    tr_mode = 1;
    run_job(5, 66, 'h013, 0, 1, 0, -1);
    f = capx(64);
    chk("t2_f64_addr", f[40:32], 6);
    chk("t2_f64_sel", f[104:41], 64'h1);
    f = capx(65);
    chk("t2_f65_addr", f[40:32], 6);
    chk("t2_f65_sel", f[104:41], 64'h2);

    tr_mode = 2;
    run_job(7, 12, 'h0A5, 0, 0, 1, -1);

    tr_mode = 0;
    run_job('h1FF, 65, 'h002, 0, 0, 0, -1);
    f = capx(63);
    chk("t4_f63_addr", f[40:32], 'h1FF);
    chk("t4_f63_sel", f[104:41], 64'h8000_0000_0000_0000);
    f = capx(64);
    chk("t4_f64_addr", f[40:32], 0);
    chk("t4_f64_sel", f[104:41], 64'h1);

    run_job(3, 0, 'h002, 0, 0, 0, -1);

    tr_mode = 1;
    run_job(0, 5, 'h044, 0, 0, 0, 2);
    tr_mode = 0;
    run_job(0, 3, 'h045, 1, 0, 0, -1);
    f = capx(0);
    chk("t6_restart_sel", f[104:41], 64'h1);
    chk("t6_restart_addr", f[40:32], 0);

    for (int j = 0; j < 10; j++) begin
      tr_mode = (j % 3 == 2) ? 2 : 1;
      run_job($urandom_range(0, 511), $urandom_range(1, 140),
              $urandom_range(0, 4095), 0, j % 2,
              bit'($urandom_range(0, 1)), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
